// File: rtl/uart_cpu_sys.sv
// rtl/uart_cpu_sys.sv - 8N1 UART receiver/transmitter with byte echo and button-triggered byte-count report
module uart_cpu_sys #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Rx,
  output logic       Tx,
  input  logic       USER_btn,
  output logic [7:0] LEDS
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  localparam logic [13:0] BIT_LAST  = 14'(CLKS_PER_BIT - 1);
  localparam logic [13:0] HALF_LAST = 14'(CLKS_PER_BIT / 2 - 1);
  // Stop bit ends one cycle early; the IDLE cycle that follows makes up the full bit.
  localparam logic [13:0] STOP_LAST = 14'(CLKS_PER_BIT - 2);

  logic [SYNC_STAGES-1:0] rx_sync_q, btn_sync_q;
  logic                   btn_prev_q;
  logic                   rx_s, btn_s, btn_fall;

  assign rx_s     = rx_sync_q[SYNC_STAGES-1];
  assign btn_s    = btn_sync_q[SYNC_STAGES-1];
  assign btn_fall = btn_prev_q & ~btn_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync_q  <= '1;
      btn_sync_q <= '1;
      btn_prev_q <= 1'b1;
    end else begin
      rx_sync_q  <= {rx_sync_q[SYNC_STAGES-2:0], Rx};
      btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], USER_btn};
      btn_prev_q <= btn_s;
    end
  end

  state_e      rx_state_q;
  logic [13:0] rx_cnt_q;
  logic [2:0]  rx_idx_q;
  logic [7:0]  rx_shift_q;
  logic        rx_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (rx_state_q)
        S_IDLE: begin
          rx_cnt_q <= '0;
          rx_idx_q <= '0;
          if (!rx_s) rx_state_q <= S_START;
        end
        S_START: begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q   <= '0;
            rx_state_q <= rx_s ? S_IDLE : S_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 14'd1;
          end
        end
        S_DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s, rx_shift_q[7:1]};
            rx_idx_q   <= rx_idx_q + 3'd1;
            if (rx_idx_q == 3'd7) rx_state_q <= S_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 14'd1;
          end
        end
        S_STOP: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_valid_q <= rx_s;
            rx_state_q <= S_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q + 14'd1;
          end
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  state_e      tx_state_q;
  logic [13:0] tx_cnt_q;
  logic [2:0]  tx_idx_q;
  logic [7:0]  tx_shift_q;
  logic        tx_q;
  logic [7:0]  leds_q, byte_cnt_q, echo_byte_q;
  logic        echo_pend_q, btn_pend_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q  <= S_IDLE;
      tx_cnt_q    <= '0;
      tx_idx_q    <= '0;
      tx_shift_q  <= '0;
      tx_q        <= 1'b1;
      leds_q      <= '0;
      byte_cnt_q  <= '0;
      echo_byte_q <= '0;
      echo_pend_q <= 1'b0;
      btn_pend_q  <= 1'b0;
    end else begin
      case (tx_state_q)
        S_IDLE: begin
          tx_cnt_q <= '0;
          tx_idx_q <= '0;
          if (echo_pend_q) begin
            tx_shift_q  <= echo_byte_q;
            echo_pend_q <= 1'b0;
            tx_q        <= 1'b0;
            tx_state_q  <= S_START;
          end else if (btn_pend_q) begin
            tx_shift_q <= byte_cnt_q;
            btn_pend_q <= 1'b0;
            tx_q       <= 1'b0;
            tx_state_q <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= '0;
            tx_q       <= tx_shift_q[0];
            tx_state_q <= S_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + 14'd1;
          end
        end
        S_DATA: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_idx_q == 3'd7) begin
              tx_q       <= 1'b1;
              tx_state_q <= S_STOP;
            end else begin
              tx_idx_q   <= tx_idx_q + 3'd1;
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_q       <= tx_shift_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 14'd1;
          end
        end
        S_STOP: begin
          if (tx_cnt_q == STOP_LAST) begin
            tx_state_q <= S_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + 14'd1;
          end
        end
        default: tx_state_q <= S_IDLE;
      endcase

      // Placed after the FSM so a request arriving as a frame starts stays pending.
      if (rx_valid_q) begin
        leds_q      <= rx_shift_q;
        byte_cnt_q  <= byte_cnt_q + 8'd1;
        echo_byte_q <= rx_shift_q;
        echo_pend_q <= 1'b1;
      end
      if (btn_fall) btn_pend_q <= 1'b1;
    end
  end

  assign Tx   = tx_q;
  assign LEDS = leds_q;

endmodule

// File: tb/tb_uart_cpu_sys.sv
// tb/tb_uart_cpu_sys.sv - scoreboard bench for uart_cpu_sys: Rx stimulus, Tx frame decoder, LEDS checks
module tb_uart_cpu_sys;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       btn = 1'b1;
  logic       tx;
  logic [7:0] leds;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         frames_seen = 0;
  bit         mon_en = 1'b1;
  logic [7:0] exp_q[$];
  int         start_q[$];

  uart_cpu_sys #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .Rx(rx), .Tx(tx), .USER_btn(btn), .LEDS(leds)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Tx frame decoder: samples mid-bit on falling clock edges, pops expected byte.
  initial begin
    logic [7:0] b;
    logic [7:0] e_byte;
    logic       st_bit, sp_bit;
    int         t0;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        t0 = cyc;
        repeat (CPB/2) @(negedge clk);
        st_bit = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        sp_bit = tx;
        if (mon_en) begin
          frames_seen++;
          start_q.push_back(t0);
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL tx_frame: unexpected frame data=%02h at cycle %0d", b, t0);
          end else begin
            e_byte = exp_q.pop_front();
            if (b !== e_byte || st_bit !== 1'b0 || sp_bit !== 1'b1) begin
              n_fail++;
              $display("FAIL tx_frame: got data=%02h start=%b stop=%b, expected data=%02h start=0 stop=1",
                       b, st_bit, sp_bit, e_byte);
            end
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic press_button(input int hold);
    btn = 1'b0;
    repeat (hold) @(negedge clk);
    btn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    repeat (CPB) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_checks++;
    if (leds !== 8'h00) begin n_fail++; $display("FAIL reset_leds: got %02h expected 00", leds); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_byte();
    logic [7:0] b;
    b = 8'h46;
    exp_q.push_back(b);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    @(negedge clk);
    n_checks++;
    if (leds !== 8'h00) begin n_fail++; $display("FAIL leds_before_stop: got %02h expected 00", leds); end
    repeat (CPB - 1) @(negedge clk);
    n_checks++;
    if (leds !== 8'h46) begin n_fail++; $display("FAIL leds_single: got %02h expected 46", leds); end
    wait_drain(30*CPB);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL echo_single: %0d frames missing expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [3];
    seq[0] = 8'h46; seq[1] = 8'h49; seq[2] = 8'h0A;
    pulse_reset();
    start_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(seq[i]);
    for (int i = 0; i < 3; i++) send_byte(seq[i], 1'b1);
    wait_drain(40*CPB);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL echo_b2b: %0d frames missing expected 0", exp_q.size()); end
    n_checks++;
    if (leds !== 8'h0A) begin n_fail++; $display("FAIL leds_b2b: got %02h expected 0a", leds); end
    n_checks++;
    if (start_q.size() != 3) begin
      n_fail++; $display("FAIL b2b_frames: got %0d frames expected 3", start_q.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_checks++;
        if (start_q[i] - start_q[i-1] != 10*CPB) begin
          n_fail++;
          $display("FAIL b2b_period: got %0d cycles expected %0d", start_q[i] - start_q[i-1], 10*CPB);
        end
      end
    end
  endtask

  task automatic test_button();
    int f0;
    f0 = frames_seen;
    exp_q.push_back(8'h03);
    press_button(40*CPB);
    repeat (20*CPB) @(negedge clk);
    n_checks++;
    if (frames_seen - f0 != 1) begin n_fail++; $display("FAIL button_count: got %0d frames expected 1", frames_seen - f0); end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL button_drain: %0d frames missing expected 0", exp_q.size()); end
  endtask

  task automatic test_framing_error();
    int f0;
    f0 = frames_seen;
    send_byte(8'h5A, 1'b0);
    repeat (20*CPB) @(negedge clk);
    n_checks++;
    if (leds !== 8'h0A) begin n_fail++; $display("FAIL frame_err_leds: got %02h expected 0a", leds); end
    n_checks++;
    if (frames_seen != f0) begin n_fail++; $display("FAIL frame_err_echo: got %0d frames expected 0", frames_seen - f0); end
    exp_q.push_back(8'h03);
    press_button(10);
    wait_drain(20*CPB);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL frame_err_count: %0d frames missing expected 0", exp_q.size()); end
  endtask

  task automatic test_glitch();
    int f0;
    f0 = frames_seen;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (20*CPB) @(negedge clk);
    n_checks++;
    if (frames_seen != f0) begin n_fail++; $display("FAIL glitch_echo: got %0d frames expected 0", frames_seen - f0); end
    n_checks++;
    if (leds !== 8'h0A) begin n_fail++; $display("FAIL glitch_leds: got %02h expected 0a", leds); end
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    wait_drain(20*CPB);
    n_checks++;
    if (leds !== 8'h55) begin n_fail++; $display("FAIL after_glitch_leds: got %02h expected 55", leds); end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL after_glitch_echo: %0d frames missing expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_echo();
    int lows;
    bit seen;
    send_byte(8'hA5, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 4*CPB && !seen; i++) begin
      if (tx === 1'b0) seen = 1'b1;
      else @(negedge clk);
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL echo_start: got no start bit expected one"); end
    mon_en = 1'b0;
    repeat (5*CPB + CPB/2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL mid_reset_tx: got %b expected 1", tx); end
    n_checks++;
    if (leds !== 8'h00) begin n_fail++; $display("FAIL mid_reset_leds: got %02h expected 00", leds); end
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 20*CPB; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    n_checks++;
    if (lows != 0) begin n_fail++; $display("FAIL no_resume: got %0d low cycles expected 0", lows); end
    mon_en = 1'b1;
    exp_q.push_back(8'h00);
    press_button(10);
    wait_drain(20*CPB);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL count_after_reset: %0d frames missing expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_button();
    test_framing_error();
    test_glitch();
    test_reset_mid_echo();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
